// File: rtl/spi_arbiter_if.sv
// Bus bundle between the two SPI requesters, the arbiter and SPI_mnrch.
// The slave modport is the arbiter's view; master is the requester/SPI side.
interface spi_arbiter_if;
  // requester 0
  logic        req0;
  logic [15:0] cmd0;
  logic        gnt0;
  logic        done0;
  // requester 1
  logic        req1;
  logic [15:0] cmd1;
  logic        gnt1;
  logic        done1;
  // shared completion information
  logic [15:0] resp;
  logic        err;
  logic        busy;
  // SPI_mnrch side
  logic        snd;
  logic [15:0] cmd;
  logic        spi_done;
  logic [15:0] spi_resp;

  modport slave (
    input  req0, cmd0, req1, cmd1, spi_done, spi_resp,
    output gnt0, done0, gnt1, done1, resp, err, busy, snd, cmd
  );

  modport master (
    output req0, cmd0, req1, cmd1, spi_done, spi_resp,
    input  gnt0, done0, gnt1, done1, resp, err, busy, snd, cmd
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI_mnrch between two requesters.
// One 16-bit transaction per grant; a watchdog aborts transactions whose
// spi_done never arrives, then waits out the stale frame before releasing.
module spi_arbiter #(
  parameter int TIMEOUT_W = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    RELEASE = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_s;
  logic                  owner_r;   // 0: requester 0, 1: requester 1
  logic                  last_r;    // requester served most recently
  logic                  err_r;     // current transaction was aborted
  logic [15:0]           cmd_r;
  logic [15:0]           resp_r;
  logic [TIMEOUT_W-1:0]  wd_r;
  logic                  pick_s;
  logic                  any_req_s;
  logic                  wd_max_s;

  // Owner selection in IDLE: a lone request wins, a tie goes to the one not served last.
  always_comb begin
    pick_s    = 1'b0;
    any_req_s = bus.req0 | bus.req1;
    wd_max_s  = (wd_r == WD_MAX);
    if (bus.req0 && bus.req1) begin
      pick_s = ~last_r;
    end else if (bus.req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; spi_done only matters in WAIT and FLUSH.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        state_s = WAIT;
      end
      WAIT: begin
        // A completion on the terminal count still takes the normal path.
        if (bus.spi_done) begin
          state_s = RELEASE;
        end else if (wd_max_s) begin
          state_s = FLUSH;
        end else begin
          state_s = WAIT;
        end
      end
      FLUSH: begin
        // Hold off any new launch until SPI_mnrch finishes the stale frame.
        if (bus.spi_done) begin
          state_s = RELEASE;
        end else begin
          state_s = FLUSH;
        end
      end
      RELEASE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath registers: owner/command latch, response capture, watchdog, round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      err_r   <= 1'b0;
      cmd_r   <= 16'h0000;
      resp_r  <= 16'h0000;
      wd_r    <= {TIMEOUT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= pick_s;
            cmd_r   <= pick_s ? bus.cmd1 : bus.cmd0;
            err_r   <= 1'b0;
          end
        end
        LAUNCH: begin
          wd_r <= {TIMEOUT_W{1'b0}};
        end
        WAIT: begin
          if (bus.spi_done) begin
            resp_r <= bus.spi_resp;
          end else if (wd_max_s) begin
            resp_r <= 16'hFFFF;
            err_r  <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_ONE;
          end
        end
        FLUSH: begin
          // Stale spi_resp is discarded; resp already holds the abort value.
          resp_r <= resp_r;
        end
        RELEASE: begin
          last_r <= owner_r;
        end
        default: begin
          owner_r <= owner_r;
        end
      endcase
    end
  end

  // Output decode from registered state; no path from reqX to snd.
  always_comb begin
    bus.gnt0  = 1'b0;
    bus.gnt1  = 1'b0;
    bus.done0 = 1'b0;
    bus.done1 = 1'b0;
    bus.err   = 1'b0;
    bus.snd   = 1'b0;
    bus.busy  = 1'b0;
    bus.cmd   = cmd_r;
    bus.resp  = resp_r;
    case (state_r)
      IDLE: begin
        bus.busy = 1'b0;
      end
      LAUNCH: begin
        bus.busy = 1'b1;
        bus.snd  = 1'b1;
        bus.gnt0 = ~owner_r;
        bus.gnt1 = owner_r;
      end
      WAIT, FLUSH: begin
        bus.busy = 1'b1;
        bus.gnt0 = ~owner_r;
        bus.gnt1 = owner_r;
      end
      RELEASE: begin
        bus.busy  = 1'b1;
        bus.done0 = ~owner_r;
        bus.done1 = owner_r;
        bus.err   = err_r;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: the bench plays both requesters and
// SPI_mnrch; expected transactions are queued on request and checked at
// launch (snd) and completion (doneX).
module tb_spi_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   num_checks = 0;
  int   num_errors = 0;

  typedef struct {
    int          who;
    logic [15:0] cmd;
    logic [15:0] resp;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic watch_gnt0;
  logic saw_gnt0;
  int   n;
  int   snd_cnt;

  spi_arbiter_if bus();

  spi_arbiter #(.TIMEOUT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int who, input logic [15:0] c, input logic [15:0] r, input logic e);
    exp_q.push_back('{who: who, cmd: c, resp: r, err: e});
  endtask

  // Waits (bounded) for the launch strobe; returns edges taken.
  task automatic wait_snd(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (bus.snd) break;
    end
    check("snd_seen", bus.snd, 1);
  endtask

  // SPI_mnrch model: after lat cycles, one-cycle spi_done with data.
  task automatic reply(input int lat, input logic [15:0] data);
    repeat (lat) tick();
    bus.spi_resp = data;
    bus.spi_done = 1'b1;
    tick();
    bus.spi_done = 1'b0;
    bus.spi_resp = 16'h0000;
  endtask

  // Called in the RELEASE cycle.
  task automatic end_txn(input int who, input logic [15:0] r, input logic e);
    check("done_owner", (who == 1) ? bus.done1 : bus.done0, 1);
    check("done_other", (who == 1) ? bus.done0 : bus.done1, 0);
    check("gnt_released", bus.gnt0 | bus.gnt1, 0);
    check("resp", bus.resp, r);
    check("err", bus.err, e);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (watch_gnt0 && bus.gnt0) saw_gnt0 = 1'b1;
      if (bus.snd) begin
        check("snd_sb", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("snd_cmd", bus.cmd, exp_q[0].cmd);
          check("snd_gnt", (exp_q[0].who == 1) ? bus.gnt1 : bus.gnt0, 1);
        end
      end
      if (bus.done0 | bus.done1) begin
        check("done_sb", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("sb_who", bus.done1, mon_e.who[0]);
          check("sb_resp", bus.resp, mon_e.resp);
          check("sb_err", bus.err, mon_e.err);
        end
      end
      if (bus.err) check("err_with_done", bus.done0 | bus.done1, 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.cmd0 = 16'h0000;
    bus.req1 = 1'b0; bus.cmd1 = 16'h0000;
    bus.spi_done = 1'b0; bus.spi_resp = 16'h0000;
    watch_gnt0 = 1'b0; saw_gnt0 = 1'b0;
    #1;
    check("rst_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.busy, bus.snd}, 0);
    check("rst_cmd", bus.cmd, 16'h0000);
    check("rst_resp", bus.resp, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single transaction from requester 0; later cmd0 changes are ignored.
    bus.req0 = 1'b1; bus.cmd0 = 16'h0D02;
    push(0, 16'h0D02, 16'h00A5, 1'b0);
    wait_snd(n);
    check("grant_latency", n, 1);
    check("gnt0_launch", bus.gnt0, 1);
    check("busy_launch", bus.busy, 1);
    bus.cmd0 = 16'hFFFF;
    tick();
    check("snd_single", bus.snd, 0);
    check("cmd_held", bus.cmd, 16'h0D02);
    reply(2, 16'h00A5);
    end_txn(0, 16'h00A5, 1'b0);
    bus.req0 = 1'b0;
    tick();
    check("busy_idle", bus.busy, 0);

    // Tie after reset: requester 0 first, then requester 1 after turnaround.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.cmd0 = 16'h1111;
    bus.req1 = 1'b1; bus.cmd1 = 16'h2222;
    push(0, 16'h1111, 16'hA001, 1'b0);
    push(1, 16'h2222, 16'hA002, 1'b0);
    wait_snd(n);
    check("tie_first0", bus.gnt0, 1);
    check("tie_gnt1_low", bus.gnt1, 0);
    reply(3, 16'hA001);
    end_txn(0, 16'hA001, 1'b0);
    bus.req0 = 1'b0;
    // spi_done edge M -> RELEASE, IDLE, LAUNCH (edge M+2)
    wait_snd(n);
    check("turnaround", n, 2);
    check("gnt1_after", bus.gnt1, 1);
    reply(1, 16'hA002);
    end_txn(1, 16'hA002, 1'b0);
    bus.req1 = 1'b0;
    tick();

    // Both re-request: alternation gives requester 0; it drops req0 while granted.
    bus.req0 = 1'b1; bus.cmd0 = 16'h3333;
    bus.req1 = 1'b1; bus.cmd1 = 16'h4444;
    push(0, 16'h3333, 16'hB001, 1'b0);
    push(1, 16'h4444, 16'hB002, 1'b0);
    wait_snd(n);
    check("alt_first0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    reply(2, 16'hB001);
    end_txn(0, 16'hB001, 1'b0);
    wait_snd(n);
    check("alt_then1", bus.gnt1, 1);
    reply(2, 16'hB002);
    end_txn(1, 16'hB002, 1'b0);
    bus.req1 = 1'b0;
    tick();

    // Requester 1 alone, held high across several transactions.
    watch_gnt0 = 1'b1; saw_gnt0 = 1'b0;
    bus.req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.cmd1 = 16'h5A00 + 16'(k);
      push(1, 16'h5A00 + 16'(k), 16'hC000 + 16'(k), 1'b0);
      wait_snd(n);
      check("r1_latency", n, (k == 0) ? 1 : 2);
      reply(1 + k, 16'hC000 + 16'(k));
      end_txn(1, 16'hC000 + 16'(k), 1'b0);
    end
    bus.req1 = 1'b0;
    tick();
    watch_gnt0 = 1'b0;
    check("no_gnt0", saw_gnt0, 0);

    // Watchdog abort: no snd while flushing, late spi_done gives done0+err, resp FFFF.
    bus.req0 = 1'b1; bus.cmd0 = 16'h5555;
    push(0, 16'h5555, 16'hFFFF, 1'b1);
    wait_snd(n);
    snd_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.snd) snd_cnt++;
    end
    check("no_snd_flush", snd_cnt, 0);
    check("gnt_hold_flush", bus.gnt0, 1);
    reply(0, 16'h1234);
    end_txn(0, 16'hFFFF, 1'b1);
    bus.req0 = 1'b0;
    tick();

    // spi_done on the terminal count (16th WAIT edge, count 15) is a normal finish.
    bus.req0 = 1'b1; bus.cmd0 = 16'h6666;
    push(0, 16'h6666, 16'hBEEF, 1'b0);
    wait_snd(n);
    reply(16, 16'hBEEF);
    end_txn(0, 16'hBEEF, 1'b0);
    bus.req0 = 1'b0;
    tick();

    // One edge later the abort has already happened.
    bus.req0 = 1'b1; bus.cmd0 = 16'h7777;
    push(0, 16'h7777, 16'hFFFF, 1'b1);
    wait_snd(n);
    reply(17, 16'h4321);
    end_txn(0, 16'hFFFF, 1'b1);
    bus.req0 = 1'b0;
    tick();

    // Asynchronous reset during WAIT, then pending req1 with a stale spi_done in IDLE.
    bus.req0 = 1'b1; bus.cmd0 = 16'h1357;
    push(0, 16'h1357, 16'h0000, 1'b0);
    wait_snd(n);
    bus.req0 = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.busy, bus.snd}, 0);
    check("arst_cmd", bus.cmd, 16'h0000);
    check("arst_resp", bus.resp, 16'h0000);
    exp_q.delete();
    bus.req1 = 1'b1; bus.cmd1 = 16'h8888;
    bus.spi_done = 1'b1; bus.spi_resp = 16'hDEAD;
    push(1, 16'h8888, 16'h9999, 1'b0);
    tick();
    rst_n = 1'b1;
    wait_snd(n);
    bus.spi_done = 1'b0; bus.spi_resp = 16'h0000;
    check("post_rst_latency", n, 1);
    check("post_rst_gnt1", bus.gnt1, 1);
    check("stale_ignored", bus.done0 | bus.done1 | bus.err, 0);
    reply(2, 16'h9999);
    end_txn(1, 16'h9999, 1'b0);
    bus.req1 = 1'b0;
    repeat (2) tick();

    check("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Two-requester arbiter that shares the single SPI_mnrch monarch between the inertial interface (requester 0) and a second SPI client (requester 1, e.g. diagnostic/register reader). It sits between the requesters and SPI_mnrch. It grants ownership round-robin, launches exactly one 16-bit transaction per grant and routes the response and completion back to the owner. A watchdog aborts ownership of transactions that never complete.

## Interface
Parameters:
- TIMEOUT_W, 12: width of the per-transaction watchdog counter; abort when count reaches 2^TIMEOUT_W-1.

Ports:
- Reset is rst_n, asynchronous, active-low; the clock is clk.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 transaction request (level); cmd0 valid while high.
- cmd0  in  16  requester 0 SPI command.
- gnt0  out  1  requester 0 owns the SPI.
- done0  out  1  1-cycle pulse: requester 0 transaction finished; resp valid.
- req1, cmd1, gnt1, done1: identical set for requester 1.
- resp  out  16  response of last finished transaction, held until next finish.
- err  out  1  1-cycle pulse coincident with doneX on a watchdog abort.
- busy  out  1  high in any state other than IDLE.
- snd  out  1  to SPI_mnrch: 1-cycle launch strobe.
- cmd  out  16  to SPI_mnrch: latched command of current owner.
- spi_done  in  1  from SPI_mnrch: transaction complete.
- spi_resp  in  16  from SPI_mnrch: received data.

## Operation
- States: IDLE, LAUNCH, WAIT, RELEASE, FLUSH.
- IDLE: if req0 or req1 is high, select the owner as follows.
  - Only one request: select it.
  - Both requests: select the requester not served last (pointer `last`).
  - Latch the owner and its cmdX into cmd, assert gntX, and go to LAUNCH.
  - With no request, stay in IDLE.
- LAUNCH: snd=1 for exactly this cycle, clear the watchdog, go to WAIT.
- WAIT:
  - On spi_done: latch resp<=spi_resp, go to RELEASE.
  - Otherwise, when the watchdog is at its maximum: latch resp<=16'hFFFF, set the error flag, go to FLUSH.
  - Otherwise increment the watchdog.
- RELEASE:
  - Outputs: doneX=1 for the owner; err=1 if entered from the abort path; gntX deasserted.
  - Actions: last<=owner; go to IDLE.
- FLUSH: internal state entered on abort. It waits for the stale spi_done and discards spi_resp. On spi_done, go to RELEASE.
  - RELEASE then pulses doneX and err with resp=16'hFFFF.
  - No new snd is issued while SPI_mnrch is still mid-frame.
- Requester rule: deassert reqX in the cycle doneX is sampled high. reqX still high in IDLE afterward is a new request.
- Requirements on the owner:
  - cmdX changes after the grant are ignored, because cmd was latched.
  - Dropping reqX while granted does not cancel the transaction; it still completes with doneX.
- spi_done outside WAIT/FLUSH is ignored.
- Reset values: gnt0=gnt1=0, done0=done1=0, err=0, busy=0, snd=0, cmd=16'h0000, resp=16'h0000, state=IDLE, last=1 (requester 0 wins the first tie), watchdog=0.
- Reset asserted mid-transaction returns everything to reset values immediately. The next snd is not blocked waiting for the SPI frame.

## Timing
- All outputs registered or decoded from state; no combinational path from reqX to snd.
- Grant latency: reqX high at edge N (IDLE) gives gntX high and cmd valid from N+1; snd high during cycle N+1 (LAUNCH).
- spi_done sampled at edge M in WAIT: resp updated and doneX high during cycle M+1 (RELEASE); gntX low from M+1.
- Earliest next grant: IDLE at M+2, new gnt at M+3. Turnaround between back-to-back transactions is 3 cycles beyond SPI time.
- Watchdog: abort after 2^TIMEOUT_W-1 WAIT cycles without spi_done. spi_done arriving in the same cycle as the terminal count takes the normal path with no err.
- busy falls at entry to IDLE.

## Test plan
- Reset, then req0 with cmd0=16'h0D02: gnt0 high next cycle, snd single pulse with cmd=16'h0D02; spi_done with spi_resp=16'h00A5 gives done0 pulse, resp=16'h00A5, err=0.
- req0 and req1 raised in the same cycle after reset: requester 0 served first. With req1 held, it is granted 3 cycles after done0. If both re-request, requester 0 is served next (alternation).
- req1 only, repeatedly with req0 low: each request served, no starvation delay beyond the 3-cycle turnaround; gnt0 never asserts.
- TIMEOUT_W=4, no spi_done: after 15 WAIT cycles the block enters FLUSH with no snd. A later spi_done gives done0 and err pulses together with resp=16'hFFFF.
- rst_n asserted during WAIT: all outputs return to reset values asynchronously. After release, a pending req1 is granted normally and the stale spi_done is ignored in IDLE.
